block_collector: RTL and testbench

- Downstream neighbour of the block distributor: collects per-lane results, each tagged with the sequence ID assigned at distribution, and re-serialises them into one in-order output stream.
- Lanes may complete out of order, so results are held in a reorder buffer (ROB) indexed by sequence ID.
- The ROB releases entries strictly in increasing sequence ID order, modulo 2^SEQUENCE_ID_WIDTH, starting from 0 after reset.

---
 rtl/block_collector.sv | 127 ++++++++++++
 tb/tb_block_collector.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_collector.sv
// rtl/block_collector.sv - reorder buffer that re-serialises tagged lane results in sequence order
module block_collector #(
  parameter int BLOCK_WIDTH       = 32,
  parameter int NUM_LANES         = 4,
  parameter int SEQUENCE_ID_WIDTH = 8,
  parameter int ROB_DEPTH         = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_LANES-1:0][BLOCK_WIDTH-1:0]         lane_data,
  input  logic [NUM_LANES-1:0][SEQUENCE_ID_WIDTH-1:0]   lane_seq_id,
  input  logic [NUM_LANES-1:0]                          lane_valid,
  output logic [NUM_LANES-1:0]                          lane_ready,
  output logic [BLOCK_WIDTH-1:0]                        data_out,
  output logic                                          data_out_valid,
  input  logic                                          data_out_ready,
  output logic [$clog2(ROB_DEPTH):0]                    rob_count,
  output logic                                          seq_err
);

  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [BLOCK_WIDTH-1:0]       slot_data_q [ROB_DEPTH];
  logic [BLOCK_WIDTH-1:0]       slot_data_d [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]         slot_valid_q, slot_valid_d;
  logic [SEQUENCE_ID_WIDTH-1:0] expected_seq_q, expected_seq_d;
  logic [BLOCK_WIDTH-1:0]       data_out_q, data_out_d;
  logic                         data_out_valid_q, data_out_valid_d;
  logic [CNT_W-1:0]             rob_count_q, rob_count_d;
  logic                         seq_err_q, seq_err_d;

  logic [NUM_LANES-1:0][SEQUENCE_ID_WIDTH-1:0] lane_dist;
  logic [NUM_LANES-1:0][IDX_W-1:0]             lane_slot;
  logic [NUM_LANES-1:0]                        in_win;
  logic [IDX_W-1:0]                            head;
  logic                                        load_en;
  logic [CNT_W-1:0]                            acc_cnt;

  // Window decode and per-lane ready; lower lane wins a contested slot.
  always_comb begin
    lane_dist  = '0;
    lane_slot  = '0;
    in_win     = '0;
    lane_ready = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_dist[i] = lane_seq_id[i] - expected_seq_q;
      in_win[i]    = lane_dist[i] < SEQUENCE_ID_WIDTH'(ROB_DEPTH);
      lane_slot[i] = lane_seq_id[i][IDX_W-1:0];
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_valid[i]) begin
        if (!in_win[i]) begin
          lane_ready[i] = 1'b1;
        end else begin
          lane_ready[i] = !slot_valid_q[lane_slot[i]];
          for (int j = 0; j < NUM_LANES; j++) begin
            if (j < i && lane_valid[j] && in_win[j] && lane_slot[j] == lane_slot[i])
              lane_ready[i] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    slot_data_d      = slot_data_q;
    slot_valid_d     = slot_valid_q;
    expected_seq_d   = expected_seq_q;
    data_out_d       = data_out_q;
    data_out_valid_d = data_out_valid_q;
    seq_err_d        = seq_err_q;
    acc_cnt          = '0;
    head             = expected_seq_q[IDX_W-1:0];
    load_en          = slot_valid_q[head] && (!data_out_valid_q || data_out_ready);

    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_valid[i] && lane_ready[i]) begin
        if (in_win[i]) begin
          slot_valid_d[lane_slot[i]] = 1'b1;
          slot_data_d[lane_slot[i]]  = lane_data[i];
          acc_cnt                    = acc_cnt + CNT_W'(1);
        end else begin
          seq_err_d = 1'b1;
        end
      end
    end

    // A written slot was empty and the released head is full, so they never collide.
    if (load_en) begin
      data_out_d         = slot_data_q[head];
      data_out_valid_d   = 1'b1;
      slot_valid_d[head] = 1'b0;
      expected_seq_d     = expected_seq_q + SEQUENCE_ID_WIDTH'(1);
    end else if (data_out_valid_q && data_out_ready) begin
      data_out_valid_d = 1'b0;
    end

    rob_count_d = rob_count_q + acc_cnt - CNT_W'(load_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ROB_DEPTH; k++) slot_data_q[k] <= '0;
      slot_valid_q     <= '0;
      expected_seq_q   <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      rob_count_q      <= '0;
      seq_err_q        <= 1'b0;
    end else begin
      slot_data_q      <= slot_data_d;
      slot_valid_q     <= slot_valid_d;
      expected_seq_q   <= expected_seq_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      rob_count_q      <= rob_count_d;
      seq_err_q        <= seq_err_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign rob_count      = rob_count_q;
  assign seq_err        = seq_err_q;

endmodule

// File: tb/tb_block_collector.sv
// tb/tb_block_collector.sv - randomized and directed bench for block_collector against a sequence-keyed model
module tb_block_collector;
  localparam int BW = 32;
  localparam int NL = 4;
  localparam int SW = 8;
  localparam int RD = 8;
  localparam int CW = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NL-1:0][BW-1:0]  lane_data;
  logic [NL-1:0][SW-1:0]  lane_seq_id;
  logic [NL-1:0]          lane_valid;
  logic [NL-1:0]          lane_ready;
  logic [BW-1:0]          data_out;
  logic                   data_out_valid;
  logic                   data_out_ready;
  logic [CW-1:0]          rob_count;
  logic                   seq_err;

  always #5 clk = ~clk;

  block_collector #(.BLOCK_WIDTH(BW), .NUM_LANES(NL), .SEQUENCE_ID_WIDTH(SW), .ROB_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n), .lane_data(lane_data), .lane_seq_id(lane_seq_id),
    .lane_valid(lane_valid), .lane_ready(lane_ready), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .rob_count(rob_count), .seq_err(seq_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending results keyed by unwrapped sequence number.
  int              m_exp  = 0;
  logic [BW-1:0]   pend [int];
  bit              m_dov  = 0;
  logic [BW-1:0]   m_dout = '0;
  bit              m_err  = 0;
  logic [BW-1:0]   out_log [$];

  function automatic logic [NL-1:0] model_ready();
    logic [NL-1:0] r;
    int            claimed [$];
    logic [SW-1:0] d;
    int            abs_id;
    bit            taken;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      if (lane_valid[i]) begin
        d = lane_seq_id[i] - m_exp[SW-1:0];
        if (int'(d) >= RD) begin
          r[i] = 1'b1;
        end else begin
          abs_id = m_exp + int'(d);
          taken  = 0;
          foreach (claimed[c]) if (claimed[c] == abs_id) taken = 1;
          r[i] = !pend.exists(abs_id) && !taken;
          claimed.push_back(abs_id);
        end
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    logic [NL-1:0] er;
    logic [SW-1:0] d;
    int            base;
    #2;
    if (!rst_n) begin
      m_exp = 0; pend.delete(); m_dov = 0; m_dout = '0; m_err = 0;
    end
    er = model_ready();
    chk("lane_ready", lane_ready, er);
    chk("data_out_valid", data_out_valid, m_dov);
    chk("data_out", data_out, m_dout);
    chk("rob_count", rob_count, pend.num());
    chk("seq_err", seq_err, m_err);
    if (rst_n) begin
      if (data_out_valid && data_out_ready) out_log.push_back(data_out);
      base = m_exp;
      if (pend.exists(m_exp) && (!m_dov || data_out_ready)) begin
        m_dout = pend[m_exp];
        pend.delete(m_exp);
        m_exp++;
        m_dov = 1;
      end else if (m_dov && data_out_ready) begin
        m_dov = 0;
      end
      for (int i = 0; i < NL; i++) begin
        if (lane_valid[i] && er[i]) begin
          d = lane_seq_id[i] - base[SW-1:0];
          if (int'(d) >= RD) m_err = 1;
          else pend[base + int'(d)] = lane_data[i];
        end
      end
    end
  end

  task automatic idle(input int n, input logic r);
    repeat (n) begin
      @(negedge clk);
      lane_valid     = '0;
      data_out_ready = r;
    end
  endtask

  task automatic send(input int ln, input int tag, input logic [BW-1:0] dat);
    bit ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      lane_valid      = '0;
      lane_valid[ln]  = 1'b1;
      lane_seq_id[ln] = tag[SW-1:0];
      lane_data[ln]   = dat;
      #1;
      if (lane_ready[ln]) ok = 1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: lane %0d tag %0d never ready", ln, tag);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; lane_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_log.delete();
  endtask

  function automatic logic [BW-1:0] wrap_val(input int k);
    return 32'h5000_0000 + BW'(k * 7);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int            next_issue;
    bit            busy [NL];
    int            r_tag [NL];
    logic [BW-1:0] r_data [NL];
    bit            any_busy;

    rst_n = 1'b0; lane_valid = '0; lane_seq_id = '0; lane_data = '0; data_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_valid", data_out_valid, 1'b0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_count", rob_count, 4'd0);
    chk("rst_err", seq_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // In-order single lane, 2-cycle latency
    data_out_ready = 1'b1;
    send(0, 0, 32'hA000_000A);
    send(0, 1, 32'hB000_000B);
    #2 chk("t1_count", rob_count, 4'd1);
    send(0, 2, 32'hC000_000C);
    #2 chk("t1_latency", data_out, 32'hA000_000A);
    idle(5, 1'b1);
    chk("t1_log_n", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("t1_log0", out_log[0], 32'hA000_000A);
      chk("t1_log1", out_log[1], 32'hB000_000B);
      chk("t1_log2", out_log[2], 32'hC000_000C);
    end

    // Out-of-order in a single cycle
    do_reset();
    @(negedge clk);
    data_out_ready = 1'b1;
    lane_valid = 4'hF;
    lane_seq_id[0] = 8'd3; lane_data[0] = 32'hD3;
    lane_seq_id[1] = 8'd1; lane_data[1] = 32'hD1;
    lane_seq_id[2] = 8'd2; lane_data[2] = 32'hD2;
    lane_seq_id[3] = 8'd0; lane_data[3] = 32'hD0;
    #1 chk("t2_ready", lane_ready, 4'hF);
    @(negedge clk);
    lane_valid = '0;
    #3 chk("t2_peak", rob_count, 4'd4);
    idle(7, 1'b1);
    chk("t2_log_n", out_log.size(), 4);
    for (int k = 0; k < 4 && k < out_log.size(); k++) chk("t2_log", out_log[k], 32'hD0 + k);

    // Backpressure until full, then drain
    do_reset();
    data_out_ready = 1'b0;
    for (int k = 0; k <= 8; k++) send(0, k, 32'hE000_0000 + k);
    @(negedge clk);
    lane_valid = '0;
    #3;
    chk("t3_full", rob_count, 4'd8);
    chk("t3_hold", data_out, 32'hE000_0000);
    @(negedge clk);
    lane_valid = 4'b0100; lane_seq_id[2] = 8'd5; lane_data[2] = 32'hBAD;
    #1 chk("t3_full_ready", lane_ready, 4'b0000);
    @(negedge clk);
    lane_valid = '0; data_out_ready = 1'b1;
    send(0, 9, 32'hE000_0009);
    idle(15, 1'b1);
    chk("t3_log_n", out_log.size(), 10);
    for (int k = 0; k < 10 && k < out_log.size(); k++) chk("t3_log", out_log[k], 32'hE000_0000 + k);

    // Out-of-window tag and same-slot contention
    do_reset();
    data_out_ready = 1'b1;
    send(0, 0, 32'h100);
    send(0, 1, 32'h101);
    idle(3, 1'b1);
    @(negedge clk);
    lane_valid = 4'b1010;
    lane_seq_id[1] = 8'd2;  lane_data[1] = 32'h102;
    lane_seq_id[3] = 8'd10; lane_data[3] = 32'hDEAD;
    #1 chk("t4_ready_oow", lane_ready, 4'b1010);
    @(negedge clk);
    lane_valid = '0;
    #3 chk("t4_seq_err", seq_err, 1'b1);
    @(negedge clk);
    lane_valid = 4'b0101;
    lane_seq_id[0] = 8'd5; lane_data[0] = 32'h105;
    lane_seq_id[2] = 8'd5; lane_data[2] = 32'h205;
    #1 chk("t4_conflict", lane_ready, 4'b0001);
    idle(3, 1'b1);

    // Wrap-around across tag 255 -> 0
    do_reset();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      data_out_ready = 1'b1;
      lane_valid = '0;
      lane_valid[k % NL] = 1'b1;
      lane_seq_id[k % NL] = k[SW-1:0];
      lane_data[k % NL] = wrap_val(k);
    end
    idle(6, 1'b1);
    chk("t5_seq_err", seq_err, 1'b0);
    chk("t5_log_n", out_log.size(), 300);
    for (int k = 0; k < 300 && k < out_log.size(); k++) chk("t5_log", out_log[k], wrap_val(k));

    // Randomized traffic with lanes stalling independently
    do_reset();
    next_issue = 0;
    for (int i = 0; i < NL; i++) busy[i] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
        if (!busy[i] && ($urandom % 3) != 0 && next_issue < m_exp + RD) begin
          busy[i] = 1; r_tag[i] = next_issue; r_data[i] = $urandom; next_issue++;
        end
        lane_valid[i]  = busy[i] && (($urandom % 4) != 0);
        lane_seq_id[i] = r_tag[i][SW-1:0];
        lane_data[i]   = r_data[i];
      end
      data_out_ready = ($urandom % 4) != 0;
      #1;
      for (int i = 0; i < NL; i++) if (lane_valid[i] && lane_ready[i]) busy[i] = 0;
    end
    any_busy = 1;
    for (int cyc = 0; cyc < 200 && any_busy; cyc++) begin
      @(negedge clk);
      data_out_ready = 1'b1;
      for (int i = 0; i < NL; i++) lane_valid[i] = busy[i];
      #1;
      for (int i = 0; i < NL; i++) if (lane_valid[i] && lane_ready[i]) busy[i] = 0;
      any_busy = 0;
      for (int i = 0; i < NL; i++) if (busy[i]) any_busy = 1;
    end
    idle(12, 1'b1);
    chk("t6_drained", rob_count, 4'd0);
    chk("t6_all_out", out_log.size(), next_issue);
    chk("t6_seq_err", seq_err, 1'b0);

    // Async reset mid-stream
    do_reset();
    data_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(0, k, 32'hF000_0000 + k);
    send(1, 200, 32'hBADBAD);
    @(negedge clk);
    lane_valid = '0;
    #3;
    chk("t7_pre_count", rob_count, 4'd3);
    chk("t7_pre_err", seq_err, 1'b1);
    chk("t7_pre_valid", data_out_valid, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_async_valid", data_out_valid, 1'b0);
    chk("t7_async_count", rob_count, 4'd0);
    chk("t7_async_err", seq_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; data_out_ready = 1'b1; out_log.delete();
    lane_valid = 4'b0001; lane_seq_id[0] = 8'd0; lane_data[0] = 32'hF0F0_1234;
    @(negedge clk);
    lane_valid = '0;
    #3 chk("t7_lat1", data_out_valid, 1'b0);
    @(negedge clk);
    #3;
    chk("t7_lat2_valid", data_out_valid, 1'b1);
    chk("t7_lat2_data", data_out, 32'hF0F0_1234);
    idle(3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
